// File: rtl/brent_kung_adder_pipe_if.sv
// Handshake and operand/result bundle for brent_kung_adder_pipe.
// The ovf/zero members exist only when BK_FLAGS_EN is defined.
interface brent_kung_adder_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef BK_FLAGS_EN
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/brent_kung_adder_pipe.sv
// Pipelined Brent-Kung add/subtract, one register stage per prefix level, valid/ready flow.
// Define BK_FLAGS_EN to add pipelined signed-overflow (ovf) and zero flags.
module brent_kung_adder_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    brent_kung_adder_pipe_if.slave bus
);
    localparam int LOGW = $clog2(WIDTH);
    localparam int NPS  = 2 * LOGW;  // stages carrying per-bit (G,P)
    localparam int LAT  = NPS + 1;

    logic [WIDTH-1:0] r_g [1:NPS];
    logic [WIDTH-1:0] r_p [1:NPS];
    logic [WIDTH-1:0] r_h [1:NPS];
    logic [NPS:1]     r_c0;
    logic [LAT:1]     r_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_g [2:NPS];
    logic [WIDTH-1:0] w_p [2:NPS];
    logic [WIDTH-1:0] w_bb, w_h1, w_g1, w_carry, w_sum;
    logic             w_c0;
    logic [LAT:1]     w_ld, w_en;

    always_comb begin
        w_bb  = bus.sub ? ~bus.b : bus.b;
        w_c0  = bus.sub | bus.cin;
        w_h1  = bus.a ^ w_bb;
        w_g1  = bus.a & w_bb;
        // Carry-in enters as g_-1, so bit 0 already holds G[0:-1]
        w_g1[0] = w_g1[0] | (w_h1[0] & w_c0);
    end

    for (genvar k = 2; k <= NPS; k++) begin : g_lvl
        localparam bit UP = (k - 1) <= LOGW;
        localparam int L  = UP ? (k - 1) : (NPS - (k - 1));
        localparam int D  = 1 << (L - 1);
        logic [WIDTH-1:0] w_gl, w_pl;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (UP ? ((i + 1) % (2 * D) == 0) : (i >= 2 * D && (i + 1) % (2 * D) == D))
            begin : g_cell
                assign w_gl[i] = r_g[k-1][i] | (r_p[k-1][i] & r_g[k-1][i-D]);
                assign w_pl[i] = r_p[k-1][i] & r_p[k-1][i-D];
            end else begin : g_pass
                assign w_gl[i] = r_g[k-1][i];
                assign w_pl[i] = r_p[k-1][i];
            end
        end
        assign w_g[k] = w_gl;
        assign w_p[k] = w_pl;
    end

    always_comb begin
        w_carry = {r_g[NPS][WIDTH-2:0], r_c0[NPS]};
        w_sum   = r_h[NPS] ^ w_carry;
    end

    // A stage may load when empty or when its successor loads this cycle
    always_comb begin : p_hs
        logic v_ld;
        w_ld      = '0;
        w_en      = '0;
        v_ld      = ~r_vld[LAT] | bus.out_ready;
        w_ld[LAT] = v_ld;
        for (int k = LAT - 1; k >= 1; k--) begin
            v_ld    = ~r_vld[k] | v_ld;
            w_ld[k] = v_ld;
        end
        w_en[1] = w_ld[1] & bus.in_valid;
        for (int k = 2; k <= LAT; k++) begin
            w_en[k] = w_ld[k] & r_vld[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= NPS; k++) begin
                r_g[k] <= '0;
                r_p[k] <= '0;
                r_h[k] <= '0;
            end
            r_c0   <= '0;
            r_vld  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            if (w_ld[1]) r_vld[1] <= bus.in_valid;
            for (int k = 2; k <= LAT; k++) begin
                if (w_ld[k]) r_vld[k] <= r_vld[k-1];
            end
            if (w_en[1]) begin
                r_g[1]  <= w_g1;
                r_p[1]  <= w_h1;
                r_h[1]  <= w_h1;
                r_c0[1] <= w_c0;
            end
            for (int k = 2; k <= NPS; k++) begin
                if (w_en[k]) begin
                    r_g[k]  <= w_g[k];
                    r_p[k]  <= w_p[k];
                    r_h[k]  <= r_h[k-1];
                    r_c0[k] <= r_c0[k-1];
                end
            end
            if (w_en[LAT]) begin
                r_sum  <= w_sum;
                r_cout <= r_g[NPS][WIDTH-1];
            end
        end
    end

    assign bus.in_ready  = w_ld[1];
    assign bus.out_valid = r_vld[LAT];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

`ifdef BK_FLAGS_EN
    logic [NPS:1] r_am, r_bm;
    logic         r_ovf, r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_am   <= '0;
            r_bm   <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_en[1]) begin
                r_am[1] <= bus.a[WIDTH-1];
                r_bm[1] <= w_bb[WIDTH-1];
            end
            for (int k = 2; k <= NPS; k++) begin
                if (w_en[k]) begin
                    r_am[k] <= r_am[k-1];
                    r_bm[k] <= r_bm[k-1];
                end
            end
            if (w_en[LAT]) begin
                r_ovf  <= (r_am[NPS] == r_bm[NPS]) & (w_sum[WIDTH-1] != r_am[NPS]);
                r_zero <= ~|w_sum;
            end
        end
    end

    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
`endif
endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// Scoreboard bench for brent_kung_adder_pipe (WIDTH=4): directed cases, exhaustive add,
// backpressure, asynchronous reset mid-flight and randomised handshake traffic.
module tb_brent_kung_adder_pipe;
    localparam int W    = 4;
    localparam int LOGW = $clog2(W);
    localparam int LAT  = 2 * LOGW + 1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           n_chk = 0;
    int           n_err = 0;
    exp_t         sb[$];
    bit           rand_rdy = 1'b0;
    bit           stalled = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    brent_kung_adder_pipe_if #(.WIDTH(W)) bus ();

    brent_kung_adder_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         e;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: push on input transfer, pop/compare on output transfer, check stall hold
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_sum", bus.sum, e.sum);
                    check("sb_cout", bus.cout, e.cout);
`ifdef BK_FLAGS_EN
                    check("sb_ovf", bus.ovf, e.ovf);
                    check("sb_zero", bus.zero, e.zero);
`endif
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (stalled) begin
                    check("hold_sum", bus.sum, hold_sum);
                    check("hold_cout", bus.cout, hold_cout);
                end
                stalled   = 1'b1;
                hold_sum  = bus.sum;
                hold_cout = bus.cout;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit acc = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        int cnt = 1;
        send(a, b, cin, sub);
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_lat"}, cnt, LAT);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, bus.cout, ec);
`ifdef BK_FLAGS_EN
        check({tag, "_ovf"}, bus.ovf, eo);
        check({tag, "_zero"}, bus.zero, ez);
`else
        if (eo === 1'bx || ez === 1'bx) check({tag, "_flag_arg"}, 64'd0, 64'd1);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [W-1:0] va;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        op_check("add_7_5",   4'd7,  4'd5, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 1'b0);
        op_check("add_15_1",  4'd15, 4'd1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
        op_check("add_7_1",   4'd7,  4'd1, 1'b0, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
        op_check("sub_3_5",   4'd3,  4'd5, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        op_check("sub_5_3",   4'd5,  4'd3, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0);
        op_check("sub_6_6c0", 4'd6,  4'd6, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
        op_check("add_9_6c1", 4'd9,  4'd6, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    send(a[W-1:0], b[W-1:0], c[0], 1'b0);
        drain();

        // Backpressure: seven back-to-back offers with the sink stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            va           = i[W-1:0];
            bus.a        = va;
            bus.b        = va + 4'd3;
            bus.cin      = i[0];
            bus.sub      = i[1];
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", sb.size(), LAT);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("bp_no_gap", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        check("bp_sb_empty", sb.size(), 0);
        check("bp_out_idle", bus.out_valid, 0);

        // Asynchronous reset with three ops in flight
        bus.out_ready = 1'b0;
        send(4'd1, 4'd2, 1'b0, 1'b0);
        send(4'd3, 4'd4, 1'b1, 1'b0);
        send(4'd9, 4'd2, 1'b0, 1'b1);
        repeat (LAT) @(posedge clk);
        #1;
        check("mid_valid_before", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_sum", bus.sum, 0);
        #1 rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("in_ready_post_rst", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random sink readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
